// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between the fetch port and the MEM-stage data port.
// Latency: req sampled in cycle 0, bus cycle from cycle 1, port ack one cycle after bus_ack (2 cycles minimum).
// Backpressure: one bus cycle outstanding, data port has fixed priority, a waiting port holds req and sees its stall high.
//
// Ports:
//   clk, rst                  core clock; asynchronous active-low reset
//   if_req/if_addr            fetch request in; if_ack/if_rdata/if_err completion out
//   d_req/d_we/d_sel/d_addr/d_wdata   data request in; d_ack/d_rdata/d_err completion out
//   bus_ce/bus_we/bus_sel/bus_addr/bus_wdata   registered bus master outputs
//   bus_rdata/bus_ack         slave response, only looked at during a bus cycle
//   if_stall_o, mem_stall_o   stall requests to the pipeline controller
//
// Build option: define ARB_TIMEOUT_EN to add a WAIT_W-bit watchdog that aborts a bus cycle
// after 2**WAIT_W-1 busy cycles without bus_ack (port gets ack with err=1, rdata=0).
// Without it a bus cycle waits for bus_ack indefinitely and the err outputs stay 0.

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic              bus_ce,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,

  output logic              if_stall_o,
  output logic              mem_stall_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_D_BUSY  = 2'd2;

  if (WAIT_W < 1 || ADDR_W < 1 || DATA_W < 1) begin : g_param_check
    $error("mem_arbiter: ADDR_W, DATA_W and WAIT_W must all be at least 1");
  end

  logic [1:0] state;
  logic       timeout;
  logic       d_new;
  logic       if_new;

  // A req still high in the cycle its own ack is out belongs to the request
  // just completed, so it must not be granted again.
  assign d_new  = d_req  & ~d_ack;
  assign if_new = if_req & ~if_ack;

  assign if_stall_o  = if_req & ~if_ack;
  assign mem_stall_o = d_req  & ~d_ack;

`ifdef ARB_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = '1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_LIMIT - WAIT_W'(1);

  logic [WAIT_W-1:0] wait_cnt;

  // wait_cnt holds the number of completed busy cycles, so the cycle that
  // sees WAIT_LAST is busy cycle number WAIT_LIMIT. A bus_ack in that same
  // cycle still completes normally.
  assign timeout = (state != ST_IDLE) & ~bus_ack & (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if (!bus_ack) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bus_ce    <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (d_new) begin
            state     <= ST_D_BUSY;
            bus_ce    <= 1'b1;
            bus_we    <= d_we;
            bus_sel   <= d_sel;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
          end else if (if_new) begin
            state     <= ST_IF_BUSY;
            bus_ce    <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'b1111;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end

        // Exit happens only on bus_ack or timeout, so ~bus_ack marks an abort.
        ST_IF_BUSY: begin
          if (bus_ack || timeout) begin
            state    <= ST_IDLE;
            bus_ce   <= 1'b0;
            if_ack   <= 1'b1;
            if_err   <= ~bus_ack;
            if_rdata <= bus_ack ? bus_rdata : '0;
          end
        end

        ST_D_BUSY: begin
          if (bus_ack || timeout) begin
            state   <= ST_IDLE;
            bus_ce  <= 1'b0;
            d_ack   <= 1'b1;
            d_err   <= ~bus_ack;
            // stores return zero, as do aborted accesses
            d_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          bus_ce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;
  localparam int LIMIT  = (1 << WAIT_W) - 1;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_sel;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              bus_ce;
  logic              bus_we;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              if_stall_o;
  logic              mem_stall_o;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- bus slave ----------------
  int          slv_busy    = 0;
  int          slv_wait    = 0;
  int          force_wait  = -1;
  int          max_wait    = 6;
  bit          slave_hang  = 1'b0;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd    = '0;

  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst || !bus_ce) begin
        slv_busy  = 0;
        bus_ack   = 1'($urandom_range(0, 1));   // idle-time noise, must be ignored
        bus_rdata = $urandom;
      end else begin
        if (slv_busy == 0)
          slv_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, max_wait));
        slv_busy++;
        if (!slave_hang && slv_busy == slv_wait + 1) begin
          bus_ack   = 1'b1;
          bus_rdata = force_rd_en ? force_rd : mem_word(bus_addr);
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- scoreboard queues: {err, rdata} ----------------
  logic [32:0] if_q[$];
  logic [32:0] d_q[$];

  // ---------------- monitor / reference model ----------------
  bit          chk_en = 1'b0;
  int          m_owner;            // 0 none, 1 fetch, 2 data
  int          m_len;              // completed busy cycles of current bus cycle
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wdata;
  logic        p_dwait, p_iwait, p_back, p_d_we;
  logic [3:0]  p_d_sel;
  logic [31:0] p_d_addr, p_d_wdata, p_if_addr;
  logic        x_if_ack, x_d_ack;
  logic [32:0] exp_resp;

  initial begin
    m_owner = 0; m_len = 0;
    p_dwait = 0; p_iwait = 0; p_back = 0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        m_owner = 0;
        m_len   = 0;
      end else begin
        x_if_ack = 1'b0;
        x_d_ack  = 1'b0;
        if (m_owner == 0) begin
          // previous cycle was idle: grant from what was waiting then, data first
          if (p_dwait) begin
            m_owner = 2; e_we = p_d_we; e_sel = p_d_sel; e_addr = p_d_addr; e_wdata = p_d_wdata;
          end else if (p_iwait) begin
            m_owner = 1; e_we = 1'b0; e_sel = 4'hF; e_addr = p_if_addr; e_wdata = '0;
          end
          m_len = 0;
        end else begin
          m_len++;
          if (p_back || (TMO && m_len == LIMIT)) begin
            if (m_owner == 1) x_if_ack = 1'b1;
            else              x_d_ack  = 1'b1;
            m_owner = 0;
          end
        end

        check("bus_ce", bus_ce, (m_owner != 0));
        if (m_owner != 0) begin
          check("bus_ctl", {bus_we, bus_sel}, {e_we, e_sel});
          check("bus_addr", bus_addr, e_addr);
          check("bus_wdata", bus_wdata, e_wdata);
        end
        check("if_ack", if_ack, x_if_ack);
        check("d_ack", d_ack, x_d_ack);
        check("if_stall", if_stall_o, if_req && !if_ack);
        check("mem_stall", mem_stall_o, d_req && !d_ack);

        if (if_ack) begin
          check("if_q_has_entry", 64'(if_q.size() != 0), 64'd1);
          if (if_q.size() != 0) begin
            exp_resp = if_q.pop_front();
            check("if_resp_err_rdata", {if_err, if_rdata}, exp_resp);
          end
        end
        if (d_ack) begin
          check("d_q_has_entry", 64'(d_q.size() != 0), 64'd1);
          if (d_q.size() != 0) begin
            exp_resp = d_q.pop_front();
            check("d_resp_err_rdata", {d_err, d_rdata}, exp_resp);
          end
        end
      end
      p_dwait   = d_req && !d_ack;
      p_iwait   = if_req && !if_ack;
      p_back    = bus_ack;
      p_d_we    = d_we;
      p_d_sel   = d_sel;
      p_d_addr  = d_addr;
      p_d_wdata = d_wdata;
      p_if_addr = if_addr;
    end
  end

  // ---------------- random requesters ----------------
  task automatic run_fetch(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      if_addr = $urandom & 32'hFFFF_FFFC;
      if_req  = 1'b1;
      if_q.push_back({1'b0, mem_word(if_addr)});
      c = 0;
      do begin tick(); c++; end while (!if_ack && c < 300);
      check("if_ack_within_bound", if_ack, 1'b1);
      if (!if_ack) begin if_req = 1'b0; return; end
      if ($urandom_range(0, 2) != 0) begin
        if_req = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    if_req = 1'b0;
  endtask

  task automatic run_data(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      d_we    = 1'($urandom_range(0, 1));
      d_sel   = 4'($urandom);
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      d_req   = 1'b1;
      d_q.push_back({1'b0, (d_we ? 32'h0 : mem_word(d_addr))});
      c = 0;
      do begin tick(); c++; end while (!d_ack && c < 300);
      check("d_ack_within_bound", d_ack, 1'b1);
      if (!d_ack) begin d_req = 1'b0; return; end
      if ($urandom_range(0, 2) != 0) begin
        d_req = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "tb_mem_arbiter stuck");
  end

  // ---------------- main sequence ----------------
  int cnt;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // reset state
    check("rst_bus_ce", bus_ce, 0);
    check("rst_bus_ctl", {bus_we, bus_sel}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_acks_errs", {if_ack, d_ack, if_err, d_err}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_stalls", {if_stall_o, mem_stall_o}, 0);

    // reset in the middle of a hung fetch
    slave_hang = 1'b1;
    if_addr = 32'h40; if_req = 1'b1;
    repeat (3) tick();
    check("pre_rst_bus_ce", bus_ce, 1);
    rst = 1'b0;
    #1;
    check("async_rst_bus_ce", bus_ce, 0);
    check("async_rst_if_ack", if_ack, 0);
    if_req = 1'b0;
    repeat (2) tick();
    check("in_rst_if_ack", if_ack, 0);
    rst = 1'b1; slave_hang = 1'b0;
    repeat (3) tick();
    check("post_rst_idle_ce", bus_ce, 0);
    check("post_rst_addr", bus_addr, 0);
    check("post_rst_outs", {if_ack, d_ack, if_err, d_err, if_stall_o, mem_stall_o}, 0);
    check("post_rst_if_rdata", if_rdata, 0);

    chk_en = 1'b1;

    // zero-wait fetch
    force_wait = 0; force_rd_en = 1'b1; force_rd = 32'h34011100;
    if_addr = 32'h4; if_req = 1'b1;
    if_q.push_back({1'b0, 32'h34011100});
    @(negedge clk);
    check("f0_c0_stall", if_stall_o, 1);
    check("f0_c0_ce", bus_ce, 0);
    tick();
    @(negedge clk);
    check("f0_c1_ce", bus_ce, 1);
    check("f0_c1_sel_we", {bus_sel, bus_we}, {4'hF, 1'b0});
    check("f0_c1_addr", bus_addr, 32'h4);
    check("f0_c1_stall", if_stall_o, 1);
    tick();
    @(negedge clk);
    check("f0_c2_ack", if_ack, 1);
    check("f0_c2_rdata", if_rdata, 32'h34011100);
    check("f0_c2_stall", if_stall_o, 0);
    tick();
    if_req = 1'b0;
    force_wait = -1; force_rd_en = 1'b0;
    tick();

    // contention: store wins, fetch follows right after d_ack
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_sel = 4'h3; d_req = 1'b1;
    if_addr = 32'h8; if_req = 1'b1;
    d_q.push_back(33'h0);
    if_q.push_back({1'b0, mem_word(32'h8)});
    tick();
    check("ct_store_first_addr", bus_addr, 32'h100);
    check("ct_store_ctl", {bus_we, bus_sel}, {1'b1, 4'h3});
    check("ct_store_wdata", bus_wdata, 32'hDEADBEEF);
    cnt = 0;
    while (!d_ack && cnt < 50) begin tick(); cnt++; end
    check("ct_d_ack_seen", d_ack, 1);
    check("ct_d_rdata_zero", d_rdata, 0);
    tick();
    check("ct_fetch_start_ce", bus_ce, 1);
    check("ct_fetch_start_addr", bus_addr, 32'h8);
    d_req = 1'b0;
    cnt = 0;
    while (!if_ack && cnt < 50) begin tick(); cnt++; end
    check("ct_if_ack_seen", if_ack, 1);
    if_req = 1'b0;
    tick();

    // load with 5 wait states, d_req held through the ack cycle
    force_wait = 5; force_rd_en = 1'b1; force_rd = 32'h12345678;
    d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h200; d_wdata = 32'h0BAD0BAD; d_req = 1'b1;
    d_q.push_back({1'b0, 32'h12345678});
    cnt = 0;
    do begin tick(); cnt++; end while (!d_ack && cnt < 50);
    check("ws_ack_cycle", cnt, 7);
    check("ws_rdata", d_rdata, 32'h12345678);
    tick();
    check("ws_no_dup_grant", bus_ce, 0);
    check("ws_single_ack", d_ack, 0);
    d_req = 1'b0;
    tick();
    check("ws_still_idle", bus_ce, 0);
    force_wait = -1; force_rd_en = 1'b0;
    tick();

    // randomized traffic on both ports
    fork
      run_fetch(40);
      run_data(40);
    join
    repeat (5) tick();
    check("if_q_drained", if_q.size(), 0);
    check("d_q_drained", d_q.size(), 0);

`ifdef ARB_TIMEOUT_EN
    // hung fetch is aborted after LIMIT busy cycles
    slave_hang = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    if_q.push_back({1'b1, 32'h0});
    cnt = 0;
    do begin tick(); cnt++; end while (!if_ack && cnt < 40);
    check("wd_ack_cycle", cnt, LIMIT + 1);
    check("wd_err", if_err, 1);
    check("wd_rdata", if_rdata, 0);
    check("wd_bus_ce", bus_ce, 0);
    if_req = 1'b0; slave_hang = 1'b0;
    repeat (2) tick();

    // bus_ack in the last busy cycle wins over the watchdog
    force_wait = LIMIT - 1; force_rd_en = 1'b1; force_rd = 32'hCAFEF00D;
    if_addr = 32'h304; if_req = 1'b1;
    if_q.push_back({1'b0, 32'hCAFEF00D});
    cnt = 0;
    do begin tick(); cnt++; end while (!if_ack && cnt < 40);
    check("wd_late_ack_cycle", cnt, LIMIT + 1);
    check("wd_late_err", if_err, 0);
    check("wd_late_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0;
    force_wait = -1; force_rd_en = 1'b0;
    repeat (2) tick();
`else
    // no watchdog: a hung fetch stays on the bus
    slave_hang = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hang_bus_ce", bus_ce, 1);
      check("hang_no_ack", if_ack, 0);
      check("hang_stall", if_stall_o, 1);
    end
    chk_en = 1'b0;
    rst = 1'b0;
    tick();
    if_req = 1'b0;
    rst = 1'b1; slave_hang = 1'b0;
    repeat (2) tick();
    check("hang_recovered_idle", bus_ce, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one external memory bus between the instruction-fetch port (pc_reg/if_id side) and the data port (MEM stage) of the 5-stage core. Registered single-outstanding-transaction arbiter: data port has fixed priority over fetch. Returns per-port acks with captured read data, and drives stall requests to the pipeline controller while a port waits. An optional watchdog aborts hung bus cycles.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
WAIT_W, 4, watchdog counter width; timeout limit = 2**WAIT_W-1 busy cycles

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  fetched instruction, valid with if_ack
if_err  out  1  fetch aborted by watchdog, valid with if_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_sel  in  4  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid with d_ack; 0 for stores
d_err  out  1  data access aborted by watchdog, valid with d_ack
bus_ce  out  1  bus cycle active
bus_we  out  1  bus write
bus_sel  out  4  bus byte enables
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data, sampled with bus_ack
bus_ack  in  1  slave completion, sampled only while bus_ce=1
if_stall_o  out  1  fetch stalled
mem_stall_o  out  1  MEM stage stalled

Behaviour:
- Reset (rst=0, async): state IDLE; bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, all acks, errs, rdata, watchdog counter = 0. Reset mid-transaction drops bus_ce immediately; no ack is issued.
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE: d_req sampled 1 -> D_BUSY; else if_req sampled 1 -> IF_BUSY; else stay. A port's req is ignored in the cycle its own ack is 1 (turnaround rule, prevents duplicate grant).
- Entering D_BUSY: bus_ce=1, bus_we=d_we, bus_sel=d_sel, bus_addr=d_addr, bus_wdata=d_wdata, all registered, held constant until exit.
- Entering IF_BUSY: bus_ce=1, bus_we=0, bus_sel=4'b1111, bus_addr=if_addr, bus_wdata=0.
- BUSY with bus_ack=1: next edge -> IDLE, bus_ce=0, matching ack=1 for exactly one cycle, rdata=bus_rdata (loads/fetch) or 0 (store), err=0.
- Latency: req sampled cycle 0, bus_ce from cycle 1; zero-wait slave (bus_ack in cycle 1) -> ack in cycle 2. Each additional wait cycle adds 1. Back-to-back minimum 2 cycles per transaction.
- Ack pulses only; rdata/err hold last value until next ack of that port.
- Priority: simultaneous d_req and if_req in IDLE -> data first; fetch granted the IDLE cycle after d_ack (if d_req low or turnaround applies).
- A request that arrives while the other port is busy waits; no preemption.
- if_stall_o = if_req & ~if_ack; mem_stall_o = d_req & ~d_ack (combinational).
- bus_ack while IDLE ignored.

Optional Feature:
ARB_TIMEOUT_EN defined: WAIT_W-bit counter cleared on BUSY entry, increments each BUSY cycle without bus_ack; on reaching 2**WAIT_W-1 without ack -> IDLE, bus_ce=0, owning port ack=1, err=1, rdata=0. bus_ack in the same cycle as the limit wins (normal completion, err=0). Not defined: no counter, BUSY waits indefinitely, if_err and d_err tied 0.

Test Plan:
- Reset: drive rst=0 mid IF_BUSY -> bus_ce=0 immediately, no if_ack; after release both reqs=0 -> stays IDLE, all outputs 0.
- Fetch, zero-wait: if_req, if_addr=0x00000004, bus_ack same cycle as bus_ce, bus_rdata=0x34011100 -> bus_sel=0xF, bus_we=0; if_ack in cycle 2 with if_rdata=0x34011100; if_stall_o 1 in cycles 0-1.
- Contention: if_req and d_req both asserted, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_sel=0x3 -> store on bus first, d_ack with d_rdata=0; fetch cycle starts the cycle after d_ack.
- Wait states: load, bus_ack after 5 wait cycles, bus_rdata=0x12345678 -> bus outputs stable throughout, single d_ack pulse, d_rdata=0x12345678, no duplicate grant when d_req held high through ack cycle.
- Watchdog (ARB_TIMEOUT_EN, WAIT_W=4): fetch, no bus_ack -> after 15 busy cycles if_ack=1, if_err=1, if_rdata=0, bus_ce=0; repeat with bus_ack on 15th cycle -> if_err=0.
- Macro off: same hung fetch held 100 cycles -> bus_ce remains 1, no if_ack, if_stall_o stays 1.
